// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC ownership, instruction-bus requests, the IF/ID register,
// MIPS delay-slot branch redirection, stall/flush handling and a 1-entry skid buffer.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_addr_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ack_i,
    input  logic [31:0] inst_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        stallreq_if_o
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t      state_reg, state_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [31:0] skid_inst_reg, skid_inst_next;
    logic        pending_reg, pending_next;
    logic [31:0] pending_target_reg, pending_target_next;
    logic        discard_reg, discard_next;
    logic [31:0] redirect_pc_reg, redirect_pc_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] inst_reg, inst_next;
    logic        valid_reg, valid_next;

    logic        branch_taken;
    logic        accept;
    logic [31:0] accept_inst;
    logic [31:0] next_fetch_pc;

    assign inst_req_o    = (state_reg == FETCH);
    assign inst_addr_o   = (state_reg == FETCH) ? fetch_pc_reg : 32'h0;
    assign stallreq_if_o = inst_req_o & ~inst_ack_i;
    assign pc_o          = pc_reg;
    assign inst_o        = inst_reg;
    assign inst_valid_o  = valid_reg;

    // A branch is only seen once: while its instruction sits valid in IF/ID and the pipe moves.
    assign branch_taken  = branch_flag_i & valid_reg & ~stall_i & ~pending_reg;
    assign next_fetch_pc = pending_reg  ? pending_target_reg :
                           branch_taken ? branch_target_addr_i :
                                          fetch_pc_reg + 32'd4;

    always_comb begin
        state_next          = state_reg;
        fetch_pc_next       = fetch_pc_reg;
        skid_inst_next      = skid_inst_reg;
        pending_next        = pending_reg;
        pending_target_next = pending_target_reg;
        discard_next        = discard_reg;
        redirect_pc_next    = redirect_pc_reg;
        pc_next             = pc_reg;
        inst_next           = inst_reg;
        valid_next          = valid_reg;
        accept              = 1'b0;
        accept_inst         = inst_rdata_i;

        if (flush_i) begin
            valid_next   = 1'b0;
            inst_next    = 32'h0;
            pending_next = 1'b0;
            // An un-acked request must complete at its original address; its word is dropped.
            if (state_reg == FETCH && !inst_ack_i) begin
                discard_next     = 1'b1;
                redirect_pc_next = flush_pc_i;
            end else begin
                discard_next  = 1'b0;
                fetch_pc_next = flush_pc_i;
                state_next    = FETCH;
            end
        end else begin
            case (state_reg)
                BOOT: state_next = FETCH;
                FETCH: begin
                    if (discard_reg) begin
                        if (inst_ack_i) begin
                            fetch_pc_next = redirect_pc_reg;
                            discard_next  = 1'b0;
                        end
                        if (!stall_i) begin
                            valid_next = 1'b0;
                            inst_next  = 32'h0;
                        end
                    end else if (inst_ack_i && stall_i) begin
                        // fetch_pc stays put in HOLD, so it doubles as the parked word's pc.
                        skid_inst_next = inst_rdata_i;
                        state_next     = HOLD;
                    end else if (inst_ack_i) begin
                        accept = 1'b1;
                    end else if (!stall_i) begin
                        valid_next = 1'b0;
                        inst_next  = 32'h0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        accept      = 1'b1;
                        accept_inst = skid_inst_reg;
                        state_next  = FETCH;
                    end
                end
                default: state_next = BOOT;
            endcase

            if (accept) begin
                pc_next       = fetch_pc_reg;
                inst_next     = accept_inst;
                valid_next    = 1'b1;
                fetch_pc_next = next_fetch_pc;
                pending_next  = 1'b0;
            end else if (branch_taken) begin
                pending_next        = 1'b1;
                pending_target_next = branch_target_addr_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= BOOT;
            fetch_pc_reg       <= RESET_PC;
            skid_inst_reg      <= 32'h0;
            pending_reg        <= 1'b0;
            pending_target_reg <= 32'h0;
            discard_reg        <= 1'b0;
            redirect_pc_reg    <= 32'h0;
            pc_reg             <= 32'h0;
            inst_reg           <= 32'h0;
            valid_reg          <= 1'b0;
        end else begin
            state_reg          <= state_next;
            fetch_pc_reg       <= fetch_pc_next;
            skid_inst_reg      <= skid_inst_next;
            pending_reg        <= pending_next;
            pending_target_reg <= pending_target_next;
            discard_reg        <= discard_next;
            redirect_pc_reg    <= redirect_pc_next;
            pc_reg             <= pc_next;
            inst_reg           <= inst_next;
            valid_reg          <= valid_next;
        end
    end

endmodule
